rom_arbiter: RTL and testbench

ROM_ARBITER -- requirements
Module: rom_arbiter

---
 rtl/rom_arbiter.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_rom_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/rom_arbiter.sv
// -----------------------------------------------------------------------------
// rom_arbiter
//
// Shares one synchronous ROM between NUM_REQ burst readers. In IDLE a
// round-robin pick selects one requester, its start address goes straight to
// the ROM in that cycle and the burst length is latched. In BURST the block
// walks the remaining addresses, one per cycle, with no new grants. Each
// issued address carries an {owner, last} tag through a two-stage pipeline, so
// the response reaches the requester exactly two cycles after the address.
//
// Ports
//   clk        in   single clock, all state on the rising edge
//   rst        in   asynchronous, active-high reset
//   req_valid  in   [NUM_REQ]             per-requester read request
//   req_addr   in   [NUM_REQ*ADDR_WIDTH]  start address, slice i = requester i
//   req_len    in   [NUM_REQ*LEN_WIDTH]   burst words minus one, slice i
//   req_ready  out  [NUM_REQ]             one-hot acceptance (combinational)
//   rom_addr   out  [ADDR_WIDTH]          address to the synchronous ROM
//   rom_data   in   [DATA_WIDTH]          ROM data, one cycle after rom_addr
//   rsp_valid  out  [NUM_REQ]             one-hot owner of rsp_data
//   rsp_data   out  [DATA_WIDTH]          returned word
//   rsp_last   out                        final word of a burst
// -----------------------------------------------------------------------------
module rom_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*LEN_WIDTH-1:0]  req_len,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [ADDR_WIDTH-1:0]         rom_addr,
    input  logic [DATA_WIDTH-1:0]         rom_data,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic                          rsp_last
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_BURST = 1'b1;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [LEN_WIDTH-1:0]  LEN_ZERO  = {LEN_WIDTH{1'b0}};
    localparam logic [LEN_WIDTH-1:0]  LEN_ONE   = {{(LEN_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [IDX_W-1:0]      IDX_ZERO  = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0]      IDX_ONE   = {{(IDX_W-1){1'b0}}, 1'b1};
    localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_REQ - 1);

    // -------------------------------------------------------------------------
    // Helper functions
    // -------------------------------------------------------------------------

    // First valid requester at or after ptr, wrapping modulo NUM_REQ.
    function automatic logic [IDX_W-1:0] rr_pick(
        input logic [NUM_REQ-1:0] valid,
        input logic [IDX_W-1:0]   ptr
    );
        logic [IDX_W-1:0] pick;
        logic             found;
        int               idx;
        pick  = ptr;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!found && valid[idx]) begin
                pick  = IDX_W'(idx);
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return pick;
    endfunction

    // Pointer to the requester following idx, wrapping modulo NUM_REQ.
    function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] idx);
        logic [IDX_W-1:0] nxt;
        if (idx == IDX_LAST) begin
            nxt = IDX_ZERO;
        end else begin
            nxt = idx + IDX_ONE;
        end
        return nxt;
    endfunction

    // Index to one-hot vector of NUM_REQ bits.
    function automatic logic [NUM_REQ-1:0] to_onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_REQ-1:0] vec;
        vec      = {NUM_REQ{1'b0}};
        vec[idx] = 1'b1;
        return vec;
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [0:0]            r_state;
    logic [IDX_W-1:0]      r_rr;
    logic [IDX_W-1:0]      r_owner;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [LEN_WIDTH-1:0]  r_remaining;
    logic [ADDR_WIDTH-1:0] r_rom_addr;

    // Tag pipeline stage 1 (aligned with rom_data) and output stage.
    logic                  r_s1_valid;
    logic [IDX_W-1:0]      r_s1_owner;
    logic                  r_s1_last;
    logic [NUM_REQ-1:0]    r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_data;
    logic                  r_rsp_last;

    // -------------------------------------------------------------------------
    // Combinational issue logic
    // -------------------------------------------------------------------------
    logic                  w_any_req;
    logic [IDX_W-1:0]      w_grant_idx;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [LEN_WIDTH-1:0]  w_sel_len;
    logic                  w_issue;
    logic [ADDR_WIDTH-1:0] w_issue_addr;
    logic [IDX_W-1:0]      w_issue_owner;
    logic                  w_issue_last;
    logic [NUM_REQ-1:0]    w_req_ready;
    logic [ADDR_WIDTH-1:0] w_rom_addr;

    // Round-robin winner and the request fields it selects.
    always_comb begin
        w_any_req   = |req_valid;
        w_grant_idx = rr_pick(req_valid, r_rr);
        w_sel_addr  = req_addr[int'(w_grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];
        w_sel_len   = req_len[int'(w_grant_idx)*LEN_WIDTH +: LEN_WIDTH];
    end

    // Decide whether an address goes to the ROM this cycle and with which tag.
    // Reset gates issue so req_ready and rom_addr stay quiet while rst is high.
    always_comb begin
        w_issue       = 1'b0;
        w_issue_addr  = r_rom_addr;
        w_issue_owner = r_owner;
        w_issue_last  = 1'b0;
        w_req_ready   = {NUM_REQ{1'b0}};
        case (r_state)
            ST_IDLE: begin
                if (w_any_req && !rst) begin
                    w_issue       = 1'b1;
                    w_issue_addr  = w_sel_addr;
                    w_issue_owner = w_grant_idx;
                    w_issue_last  = (w_sel_len == LEN_ZERO);
                    w_req_ready   = to_onehot(w_grant_idx);
                end else begin
                    w_issue = 1'b0;
                end
            end
            ST_BURST: begin
                // remaining is never zero here; 1 means this is the final word
                if (!rst) begin
                    w_issue       = 1'b1;
                    w_issue_addr  = r_addr;
                    w_issue_owner = r_owner;
                    w_issue_last  = (r_remaining == LEN_ONE);
                end else begin
                    w_issue = 1'b0;
                end
            end
            default: begin
                w_issue = 1'b0;
            end
        endcase
        // rom_addr holds the last issued address when nothing is issued
        if (w_issue) begin
            w_rom_addr = w_issue_addr;
        end else begin
            w_rom_addr = r_rom_addr;
        end
    end

    assign req_ready = w_req_ready;
    assign rom_addr  = w_rom_addr;

    // -------------------------------------------------------------------------
    // Sequential logic
    // -------------------------------------------------------------------------

    // Arbitration FSM, round-robin pointer and burst address/length counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_rr        <= IDX_ZERO;
            r_owner     <= IDX_ZERO;
            r_addr      <= {ADDR_WIDTH{1'b0}};
            r_remaining <= LEN_ZERO;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_owner     <= w_grant_idx;
                        r_addr      <= w_sel_addr + ADDR_ONE;
                        r_remaining <= w_sel_len;
                        r_rr        <= rr_next(w_grant_idx);
                        if (w_sel_len == LEN_ZERO) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_state <= ST_BURST;
                        end
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_BURST: begin
                    r_addr      <= r_addr + ADDR_ONE;
                    r_remaining <= r_remaining - LEN_ONE;
                    if (r_remaining == LEN_ONE) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_state <= ST_BURST;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Remember the last issued ROM address so it can be held on idle cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rom_addr <= {ADDR_WIDTH{1'b0}};
        end else if (w_issue) begin
            r_rom_addr <= w_issue_addr;
        end else begin
            r_rom_addr <= r_rom_addr;
        end
    end

    // Tag stage 1: travels alongside the ROM's own one-cycle read latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_owner <= IDX_ZERO;
            r_s1_last  <= 1'b0;
        end else begin
            r_s1_valid <= w_issue;
            if (w_issue) begin
                r_s1_owner <= w_issue_owner;
                r_s1_last  <= w_issue_last;
            end else begin
                r_s1_owner <= r_s1_owner;
                r_s1_last  <= r_s1_last;
            end
        end
    end

    // Output stage: register ROM data together with the decoded tag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp_valid <= {NUM_REQ{1'b0}};
            r_rsp_data  <= {DATA_WIDTH{1'b0}};
            r_rsp_last  <= 1'b0;
        end else begin
            if (r_s1_valid) begin
                r_rsp_valid <= to_onehot(r_s1_owner);
                r_rsp_data  <= rom_data;
                r_rsp_last  <= r_s1_last;
            end else begin
                r_rsp_valid <= {NUM_REQ{1'b0}};
                r_rsp_data  <= r_rsp_data;
                r_rsp_last  <= 1'b0;
            end
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_last  = r_rsp_last;

endmodule

// File: tb/tb_rom_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rom_arbiter
//
// Directed bench for rom_arbiter. A behavioural ROM returns addr+0x10 one cycle
// after the address. Every expected issue pushes the response it should
// produce (owner, data, last, due cycle) into a scoreboard queue; each clock
// step pops and compares the entry due that cycle, or checks that no response
// appears.
// -----------------------------------------------------------------------------
module tb_rom_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_addr;
    logic [15:0] req_len;
    logic [3:0]  req_ready;
    logic [7:0]  rom_addr;
    logic [7:0]  rom_data;
    logic [3:0]  rsp_valid;
    logic [7:0]  rsp_data;
    logic        rsp_last;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        int         due;
        logic [3:0] v;
        logic [7:0] d;
        logic       l;
    } exp_t;

    exp_t sbq[$];

    rom_arbiter #(
        .NUM_REQ    (4),
        .ADDR_WIDTH (8),
        .DATA_WIDTH (8),
        .LEN_WIDTH  (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_len   (req_len),
        .req_ready (req_ready),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_last  (rsp_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous ROM model: ROM[i] = i + 0x10
    always @(posedge clk) rom_data <= rom_addr + 8'h10;

    function automatic logic [3:0] oh(input int i);
        logic [3:0] v;
        v = 4'h0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic set_req(input int i, input logic [7:0] a, input logic [3:0] l);
        req_addr[i*8 +: 8] = a;
        req_len[i*4 +: 4]  = l;
    endtask

    // Advance one clock and check the response port against the scoreboard.
    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (sbq.size() > 0 && sbq[0].due == cyc) begin
            e = sbq.pop_front();
            chk("rsp_valid", {28'd0, rsp_valid}, {28'd0, e.v});
            chk("rsp_data",  {24'd0, rsp_data},  {24'd0, e.d});
            chk("rsp_last",  {31'd0, rsp_last},  {31'd0, e.l});
        end else begin
            chk("rsp_quiet", {28'd0, rsp_valid}, 32'd0);
        end
    endtask

    // Check this cycle's issue and queue the response it must produce.
    task automatic expect_issue(input string tag, input logic [3:0] rdy,
                                input logic [7:0] addr, input logic [3:0] owner,
                                input logic last);
        exp_t e;
        #1;
        chk({tag, "_ready"}, {28'd0, req_ready}, {28'd0, rdy});
        chk({tag, "_addr"},  {24'd0, rom_addr},  {24'd0, addr});
        e.due = cyc + 2;
        e.v   = owner;
        e.d   = addr + 8'h10;
        e.l   = last;
        sbq.push_back(e);
    endtask

    task automatic expect_idle(input string tag, input logic [7:0] hold);
        #1;
        chk({tag, "_ready"}, {28'd0, req_ready}, 32'd0);
        chk({tag, "_addr"},  {24'd0, rom_addr},  {24'd0, hold});
    endtask

    initial begin
        logic [7:0] a;
        int         g;
        rst       = 1'b1;
        req_valid = 4'h0;
        req_addr  = 32'h0;
        req_len   = 16'h0;

        // Reset state, with requests present that must not be granted
        step();
        req_valid = 4'hF;
        #1;
        chk("rst_ready",     {28'd0, req_ready}, 32'd0);
        chk("rst_rom_addr",  {24'd0, rom_addr},  32'd0);
        chk("rst_rsp_valid", {28'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_data",  {24'd0, rsp_data},  32'd0);
        chk("rst_rsp_last",  {31'd0, rsp_last},  32'd0);
        step();

        // Round robin: all valid, len 0 -> grants 0,1,2,3,0 from release
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a = 8'h20 + 8'(i * 4);
            set_req(i, a, 4'h0);
        end
        req_valid = 4'hF;
        for (int k = 0; k < 5; k++) begin
            g = k % 4;
            a = 8'h20 + 8'(g * 4);
            expect_issue("rr", oh(g), a, oh(g), 1'b1);
            step();
        end
        req_valid = 4'h0;
        expect_idle("rr_hold", 8'h20);
        step();
        step();

        // Single word: requester 0, addr 0x05 -> data 0x15, last
        set_req(0, 8'h05, 4'h0);
        req_valid = 4'h1;
        expect_issue("single", 4'h1, 8'h05, 4'h1, 1'b1);
        step();
        req_valid = 4'h0;
        expect_idle("single_hold", 8'h05);
        step();
        step();

        // Burst with address wrap; field changes during the burst are ignored
        set_req(2, 8'hFE, 4'h3);
        req_valid = 4'h4;
        expect_issue("wrap0", 4'h4, 8'hFE, 4'h4, 1'b0);
        step();
        set_req(2, 8'h33, 4'h0);
        expect_issue("wrap1", 4'h0, 8'hFF, 4'h4, 1'b0);
        step();
        expect_issue("wrap2", 4'h0, 8'h00, 4'h4, 1'b0);
        step();
        req_valid = 4'h0;
        expect_issue("wrap3", 4'h0, 8'h01, 4'h4, 1'b1);
        step();
        expect_idle("wrap_hold", 8'h01);
        step();
        step();
        step();

        // Contention: req1 bursts len 2, req0 waits, then rr points to 1
        set_req(1, 8'h40, 4'h2);
        set_req(0, 8'h50, 4'h0);
        req_valid = 4'h2;
        expect_issue("cont_b0", 4'h2, 8'h40, 4'h2, 1'b0);
        step();
        req_valid = 4'h3;
        expect_issue("cont_b1", 4'h0, 8'h41, 4'h2, 1'b0);
        step();
        expect_issue("cont_b2", 4'h0, 8'h42, 4'h2, 1'b1);
        step();
        set_req(1, 8'h40, 4'h0);
        expect_issue("cont_g0", 4'h1, 8'h50, 4'h1, 1'b1);
        step();
        expect_issue("cont_rr", 4'h2, 8'h40, 4'h2, 1'b1);
        step();
        req_valid = 4'h0;
        expect_idle("cont_hold", 8'h40);
        step();
        step();
        step();

        // Reset during word 2 of a len 5 burst
        set_req(3, 8'h80, 4'h5);
        req_valid = 4'h8;
        expect_issue("mid_w0", 4'h8, 8'h80, 4'h8, 1'b0);
        step();
        #1;
        chk("mid_w1_addr", {24'd0, rom_addr}, 32'h81);
        rst = 1'b1;
        #1;
        chk("mid_rst_ready",     {28'd0, req_ready}, 32'd0);
        chk("mid_rst_rom_addr",  {24'd0, rom_addr},  32'd0);
        chk("mid_rst_rsp_valid", {28'd0, rsp_valid}, 32'd0);
        chk("mid_rst_rsp_data",  {24'd0, rsp_data},  32'd0);
        chk("mid_rst_rsp_last",  {31'd0, rsp_last},  32'd0);
        sbq.delete();
        step();
        rst = 1'b0;
        set_req(0, 8'h90, 4'h0);
        req_valid = 4'h1;
        expect_issue("post_rst", 4'h1, 8'h90, 4'h1, 1'b1);
        step();
        req_valid = 4'h0;
        step();
        step();
        step();

        chk("sb_empty", sbq.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
